// File: rtl/drs_trigger_ctrl.sv
// drs_trigger_ctrl: merges trigger sources, prescales them and gates single-cycle triggers to the DRS controller.
// Define DRS_TRG_PERIODIC_EN to add the periodic trigger source driven by period_i.
module drs_trigger_ctrl #(
  parameter int HOLDOFF_W    = 16,
  parameter int BUSY_TIMEOUT = 15
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 resync_i,
  input  logic                 enable_i,
  input  logic                 ext_trigger_i,
  input  logic                 sw_trigger_i,
  input  logic [7:0]           prescale_i,
  input  logic [HOLDOFF_W-1:0] holdoff_i,
  input  logic [31:0]          period_i,
  input  logic                 drs_busy_i,
  output logic                 trigger_o,
  output logic                 busy_o,
  output logic [31:0]          event_counter_o,
  output logic [15:0]          lost_event_counter_o,
  output logic [31:0]          deadtime_counter_o,
  output logic [2:0]           state_o
);
  typedef enum logic [2:0] {IDLE = 3'd0, ARMED = 3'd1, WAIT_BUSY = 3'd2, BUSY = 3'd3, HOLDOFF = 3'd4} state_t;
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  state_t               state_q, state_d;
  logic                 busy_q, trig_q, ext_q;
  logic [7:0]           pre_q, pre_d;
  logic [HOLDOFF_W-1:0] hold_q, hold_d;
  logic [TW-1:0]        wait_q, wait_d;
  logic [31:0]          ev_q, ev_d, dead_q, dead_d;
  logic [15:0]          lost_q, lost_d;
  logic                 tick, cand, accept, in_seq;
`ifdef DRS_TRG_PERIODIC_EN
  logic [31:0] per_q;
  assign tick = state_q != IDLE && period_i != '0 && per_q >= period_i - 32'd1;
  always_ff @(posedge clock) begin
    if (reset || resync_i) per_q <= '0;
    else if (state_q != IDLE && period_i != '0) per_q <= tick ? '0 : per_q + 32'd1;
  end
`else
  logic unused_period;
  assign unused_period = ^period_i;
  assign tick = 1'b0;
`endif
  always_comb begin
    cand    = (ext_trigger_i & ~ext_q) | sw_trigger_i | tick;
    accept  = state_q == ARMED && enable_i && cand && pre_q == prescale_i;
    in_seq  = state_q == WAIT_BUSY || state_q == BUSY || state_q == HOLDOFF;
    pre_d   = (resync_i || accept) ? '0 : (state_q == ARMED && enable_i && cand) ? pre_q + 8'd1 : pre_q;
    ev_d    = resync_i ? '0 : ev_q + 32'(trig_q);
    lost_d  = resync_i ? '0 : (enable_i && cand && in_seq && lost_q != '1) ? lost_q + 16'd1 : lost_q;
    dead_d  = resync_i ? '0 : (enable_i && state_q != ARMED && dead_q != '1) ? dead_q + 32'd1 : dead_q;
    state_d = state_q;
    wait_d  = wait_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: if (enable_i) state_d = ARMED;
      ARMED:
        if (!enable_i) state_d = IDLE;
        else if (accept) begin
          state_d = WAIT_BUSY;
          wait_d  = '0;
        end
      WAIT_BUSY:
        if (drs_busy_i) state_d = BUSY;
        else if (wait_q == TW'(BUSY_TIMEOUT - 1)) begin
          state_d = HOLDOFF;
          hold_d  = '0;
        end else wait_d = wait_q + TW'(1);
      BUSY:
        if (!drs_busy_i) begin
          state_d = HOLDOFF;
          hold_d  = '0;
        end
      HOLDOFF:
        if (hold_q == holdoff_i) state_d = enable_i ? ARMED : IDLE;
        else hold_d = hold_q + HOLDOFF_W'(1);
      default: state_d = IDLE;
    endcase
  end
  // ext_q resets high so a level already present at reset is not an edge
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b1;
      trig_q  <= 1'b0;
      ext_q   <= 1'b1;
      pre_q   <= '0;
      hold_q  <= '0;
      wait_q  <= '0;
      ev_q    <= '0;
      lost_q  <= '0;
      dead_q  <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= state_d != ARMED;
      trig_q  <= accept;
      ext_q   <= ext_trigger_i;
      pre_q   <= pre_d;
      hold_q  <= hold_d;
      wait_q  <= wait_d;
      ev_q    <= ev_d;
      lost_q  <= lost_d;
      dead_q  <= dead_d;
    end
  end
  assign trigger_o            = trig_q;
  assign busy_o               = busy_q;
  assign state_o              = state_q;
  assign event_counter_o      = ev_q;
  assign lost_event_counter_o = lost_q;
  assign deadtime_counter_o   = dead_q;
endmodule

// File: tb/tb_drs_trigger_ctrl.sv
// tb_drs_trigger_ctrl: directed stimulus against a timer-based behavioural model plus literal spot checks.
module tb_drs_trigger_ctrl;
  logic        clock = 0, reset = 1, resync = 0, enable = 0, ext = 0, sw = 0, busy = 0;
  logic [7:0]  prescale = 0;
  logic [15:0] holdoff = 0;
  logic [31:0] period = 0;
  logic        trigger_o, busy_o;
  logic [31:0] event_o, dead_o;
  logic [15:0] lost_o;
  logic [2:0]  state_o;
  int total = 0, bad = 0, n_trig = 0, base = 0, n = 0;
  bit go = 0;
  int m_st = 0, m_left = 0;
  bit m_trig = 0, m_ext = 1, tick = 0, cand = 0, acc = 0;
  longint m_ev = 0, m_lost = 0, m_dead = 0, m_pre = 0, m_per = 0;

  drs_trigger_ctrl dut (
    .clock(clock), .reset(reset), .resync_i(resync), .enable_i(enable),
    .ext_trigger_i(ext), .sw_trigger_i(sw), .prescale_i(prescale), .holdoff_i(holdoff),
    .period_i(period), .drs_busy_i(busy), .trigger_o(trigger_o), .busy_o(busy_o),
    .event_counter_o(event_o), .lost_event_counter_o(lost_o),
    .deadtime_counter_o(dead_o), .state_o(state_o)
  );

  initial forever #5 clock = ~clock;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(posedge clock);
    #1;
  endtask

  task automatic wait_st(input int s, input int lim);
    int i = 0;
    while (state_o != 3'(s) && i < lim) begin
      step(1);
      i++;
    end
    chk("wait_state", longint'(state_o), s);
  endtask

  // model: sequence expressed as countdown timers, states 0 idle 1 armed 2 wait 3 busy 4 holdoff
  task automatic model_step();
    if (reset) begin
      m_st = 0; m_left = 0; m_trig = 0; m_ext = 1;
      m_ev = 0; m_lost = 0; m_dead = 0; m_pre = 0; m_per = 0;
      return;
    end
`ifdef DRS_TRG_PERIODIC_EN
    tick = m_st != 0 && period != 0 && m_per == longint'(period) - 1;
    if (resync) m_per = 0;
    else if (m_st != 0 && period != 0) m_per = tick ? 0 : m_per + 1;
`else
    tick = 0;
`endif
    cand = (ext && !m_ext) || sw || tick;
    acc = m_st == 1 && enable && cand && m_pre == longint'(prescale);
    m_ev = resync ? 0 : (m_ev + longint'(m_trig)) % (64'd1 << 32);
    m_lost = resync ? 0 : (enable && cand && m_st >= 2 && m_lost < 65535) ? m_lost + 1 : m_lost;
    m_dead = resync ? 0 : (enable && m_st != 1 && m_dead < 64'hFFFF_FFFF) ? m_dead + 1 : m_dead;
    m_pre = (resync || acc) ? 0 : (m_st == 1 && enable && cand) ? m_pre + 1 : m_pre;
    if (m_st == 0) m_st = enable ? 1 : 0;
    else if (m_st == 1) begin
      if (!enable) m_st = 0;
      else if (acc) begin m_st = 2; m_left = 15; end
    end else if (m_st == 2) begin
      if (busy) m_st = 3;
      else begin
        m_left--;
        if (m_left == 0) begin m_st = 4; m_left = int'(holdoff) + 1; end
      end
    end else if (m_st == 3) begin
      if (!busy) begin m_st = 4; m_left = int'(holdoff) + 1; end
    end else begin
      m_left--;
      if (m_left == 0) m_st = enable ? 1 : 0;
    end
    m_trig = acc;
    m_ext = ext;
  endtask

  initial forever begin
    @(posedge clock);
    model_step();
  end

  initial forever begin
    @(negedge clock);
    if (trigger_o) n_trig++;
    if (go) begin
      chk("trigger_o", longint'(trigger_o), longint'(m_trig));
      chk("busy_o", longint'(busy_o), longint'(m_st != 1));
      chk("state_o", longint'(state_o), m_st);
      chk("event", longint'(event_o), m_ev);
      chk("lost", longint'(lost_o), m_lost);
      chk("dead", longint'(dead_o), m_dead);
    end
  end

  initial begin
    step(3);
    chk("rst_state", longint'(state_o), 0);
    chk("rst_busy", longint'(busy_o), 1);
    chk("rst_trig", longint'(trigger_o), 0);
    chk("rst_event", longint'(event_o), 0);
    go = 1;
    reset = 0;
    enable = 1; holdoff = 4; prescale = 0;
    step(2);
    resync = 1;
    step(1);
    resync = 0;
    ext = 1;
    step(1);
    chk("basic_trig_hi", longint'(trigger_o), 1);
    chk("basic_ev_lag", longint'(event_o), 0);
    ext = 0;
    step(1);
    chk("basic_trig_lo", longint'(trigger_o), 0);
    chk("basic_event", longint'(event_o), 1);
    busy = 1;
    step(10);
    busy = 0;
    step(5);
    chk("basic_holdoff", longint'(state_o), 4);
    step(1);
    chk("basic_rearm", longint'(state_o), 1);
    chk("basic_dead", longint'(dead_o), 17);

    prescale = 2;
    base = n_trig;
    for (int k = 1; k <= 9; k++) begin
      sw = 1;
      step(1);
      sw = 0;
      step(49);
      chk("prescale_cum", n_trig - base, k / 3);
    end
    chk("prescale_lost", longint'(lost_o), 0);
    chk("prescale_event", longint'(event_o), 4);

    prescale = 0;
    sw = 1;
    step(1);
    sw = 0;
    n = 0;
    while (state_o == 3'd2 && n < 40) begin
      n++;
      step(1);
    end
    chk("timeout_len", n, 15);
    chk("timeout_holdoff", longint'(state_o), 4);
    wait_st(1, 20);

    sw = 1;
    step(1);
    sw = 0;
    resync = 1;
    chk("resync_trig", longint'(trigger_o), 1);
    step(1);
    resync = 0;
    chk("resync_event", longint'(event_o), 0);
    wait_st(1, 40);

    sw = 1;
    step(1);
    sw = 0;
    step(1);
    busy = 1; enable = 0; sw = 1;
    step(1);
    sw = 0;
    step(4);
    chk("endrop_busy", longint'(state_o), 3);
    busy = 0;
    wait_st(0, 30);
    chk("endrop_lost", longint'(lost_o), 0);
    enable = 1;
    step(2);

    sw = 1; busy = 1;
    step(70000);
    chk("sat_lost", longint'(lost_o), 65535);
    step(5);
    chk("sat_hold", longint'(lost_o), 65535);
    sw = 0; busy = 0;
    wait_st(1, 40);

    sw = 1;
    step(1);
    sw = 0;
    step(1);
    busy = 1;
    step(4);
    chk("mid_busy", longint'(state_o), 3);
    ext = 1; reset = 1;
    step(1);
    chk("mrst_state", longint'(state_o), 0);
    chk("mrst_busy", longint'(busy_o), 1);
    chk("mrst_trig", longint'(trigger_o), 0);
    chk("mrst_event", longint'(event_o), 0);
    chk("mrst_lost", longint'(lost_o), 0);
    chk("mrst_dead", longint'(dead_o), 0);
    reset = 0; busy = 0;
    base = n_trig;
    step(5);
    chk("level_no_trig", n_trig - base, 0);
    ext = 0;
    step(2);
`ifdef DRS_TRG_PERIODIC_EN
    holdoff = 0; period = 100; reset = 1;
    step(1);
    reset = 0;
    base = n_trig;
    step(1005);
    chk("periodic_count", n_trig - base, 10);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
